rf_plus_alu: RTL and testbench
==============================

Name: rf_plus_alu

Overview:
- Datapath slice of the multicycle RISC core: an 8 x 16-bit register file (ID stage), an ID/EXE operand buffer, and a 16-bit add/subtract ALU with C/Z/N flags (EXE stage).
- Write-back into the register file is driven by the external control FSM. Data comes from external memory data (WBData) or from the internal EXE result.
- All sequencing comes from the control inputs; the block holds no FSM of its own.

Parameters:
- DW, 16, data/register width
- NREG, 8, number of registers (3-bit address)

Ports:
- clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Ins  in  16  current instruction; fields [10:8] rd, [7:5] rm, [4:2] rn, [4:0] imm5, [7:0] imm8
- WBData  in  16  external write-back data (memory read data)
- WBRF  in  1  register-file write enable
- WBresource  in  1  write-back source: 0 = WBData, 1 = internal result
- RBresource  in  1  read port B address: 0 = Ins[4:2], 1 = Ins[10:8]
- OprandB  in  1  ALU operand B: 0 = read port B, 1 = zero-extended Ins[4:0]
- LI  in  1  load-immediate select, latched into EXE
- Buff_IDEXE  in  1  load enable of ID/EXE buffer
- ALUop  in  1  0 = add, 1 = subtract
- Flag  in  1  1 = include PSW_C as carry/borrow-in
- PSW_C  in  1  stored carry flag from PSW
- Rm  out  8  DataA[7:0], combinational
- Rd  out  8  RF[Ins[10:8]][7:0], combinational
- IL_EXE  out  16  latched load-immediate value
- OutR  out  16  latched operand A (A_EXE)
- Sum  out  16  ALU result, combinational
- C  out  1  carry out (add) / borrow (sub)
- Z  out  1  Sum == 0
- N  out  1  Sum[15]

Behaviour:
- Register file reads (combinational, no write bypass):
  - DataA = RF[Ins[7:5]].
  - DataB = RF[RBresource ? Ins[10:8] : Ins[4:2]].
  - A read of a register being written in the same cycle returns the old value.
- Register file write: at posedge, if WBRF=1 and Reset=0, RF[Ins[10:8]] <= WBdin.
  - WBdin = WBData when WBresource=0.
  - WBdin = (LI_EXE ? IL_EXE : Sum) when WBresource=1.
- ID/EXE buffer: at posedge, if Buff_IDEXE=1, these registers load:
  - A_EXE <= DataA.
  - B_EXE <= OprandB ? {11'b0, Ins[4:0]} : DataB.
  - LI_EXE <= LI.
  - IL_EXE <= RBresource ? {Ins[7:0], DataB[7:0]} (LHI) : {8'h00, Ins[7:0]} (LLI).
  - When Buff_IDEXE=0, all of these hold.
- ALU (combinational on A_EXE, B_EXE), with cin = Flag & PSW_C:
  - Add: {C, Sum} = A_EXE + B_EXE + cin, as a 17-bit result.
  - Sub: Sum = A_EXE - B_EXE - cin; C = 1 if A_EXE < B_EXE + cin (borrow), unsigned.
  - Z = (Sum == 16'h0000); N = Sum[15].
  - Wrap-around is modulo 2^16.
- OutR = A_EXE.
- Reset (synchronous, active-high; has priority over write and buffer load):
  - All 8 registers, A_EXE, B_EXE, IL_EXE and LI_EXE are cleared to 0.
  - After reset: OutR=0, IL_EXE=0, Rm=0, Rd=0.
  - With ALUop=0 and Flag=0: Sum=0, C=0, Z=1, N=0.
- Simultaneous WBRF=1 and Buff_IDEXE=1: both occur. The buffer captures the pre-write RF values.
- Reset asserted mid-operation: state is cleared on that edge and any pending write is discarded.

Test Plan:
- Reset then write 8 registers: Reset=1 for 2 cycles, then WBRF=1, WBresource=0, Ins[10:8]=i, WBData=16'h1000+i.
  - Required: Rd reads 8'h00+i for each i.
  - Required: outputs are zero immediately after reset.
- LLI: Ins=16'h0?A5 (rd=3), LI=1, RBresource=0, Buff_IDEXE=1 -> IL_EXE=16'h00A5.
  - Next cycle WBRF=1, WBresource=1 -> RF[3]=16'h00A5.
- LHI: RF[2]=16'h1234, Ins[10:8]=2, Ins[7:0]=8'h5C, LI=1, RBresource=1 -> IL_EXE=16'h5C34.
  - Write-back -> RF[2]=16'h5C34.
- ADD/ADC:
  - A=16'hFFFF, B=16'h0001, ALUop=0, Flag=0 -> Sum=0, C=1, Z=1, N=0.
  - Same operands with Flag=1, PSW_C=1 -> Sum=1, C=1, Z=0.
- SUB/SBB:
  - A=16'h0003, B=16'h0005, ALUop=1 -> Sum=16'hFFFE, C=1, N=1.
  - A=5, B=5 -> Sum=0, Z=1, C=0.
  - A=5, B=5, Flag=1, PSW_C=1 -> Sum=16'hFFFF, C=1.
- Immediate operand and hold: OprandB=1, Ins[4:0]=5'h1F, RF[rm]=16'h0010 -> Sum=16'h002F on add.
  - Buff_IDEXE=0 with Ins changed -> Sum and OutR unchanged.
  - WBRF=1 and Buff_IDEXE=1 on the same edge -> the buffer captures the old RF value.

Source files
------------

// File: rtl/rf_plus_alu.sv
// Purpose: ID/EXE datapath slice: 8x16 register file, ID/EXE operand buffer, add/sub ALU with C/Z/N.
// Latency: RF reads and ALU outputs are combinational; RF writes and buffer loads commit on the next clk edge.
// Backpressure: none; the external control FSM sequences every write and buffer load.
//
// Ports:
//   clk, Reset             - clock, synchronous active-high reset
//   Ins                    - instruction: [10:8] rd, [7:5] rm, [4:2] rn, [4:0] imm5, [7:0] imm8
//   WBData, WBRF           - external write-back data, register-file write enable
//   WBresource             - write-back source select (0 external data, 1 internal result)
//   RBresource             - read port B address select (0 rn, 1 rd); also picks LHI vs LLI
//   OprandB, LI            - immediate operand select, load-immediate select
//   Buff_IDEXE             - ID/EXE buffer load enable
//   ALUop, Flag, PSW_C     - add/sub select, carry-in enable, stored carry
//   Rm, Rd                 - low bytes of read port A and of RF[rd]
//   IL_EXE, OutR           - latched load-immediate value, latched operand A
//   Sum, C, Z, N           - ALU result and flags
module rf_plus_alu #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic [15:0]   Ins,
  input  logic [DW-1:0] WBData,
  input  logic          WBRF,
  input  logic          WBresource,
  input  logic          RBresource,
  input  logic          OprandB,
  input  logic          LI,
  input  logic          Buff_IDEXE,
  input  logic          ALUop,
  input  logic          Flag,
  input  logic          PSW_C,
  output logic [7:0]    Rm,
  output logic [7:0]    Rd,
  output logic [DW-1:0] IL_EXE,
  output logic [DW-1:0] OutR,
  output logic [DW-1:0] Sum,
  output logic          C,
  output logic          Z,
  output logic          N
);

  logic [DW-1:0] rf [NREG];
  logic [DW-1:0] a_exe;
  logic [DW-1:0] b_exe;
  logic          li_exe;

  logic [2:0]    rd_addr;
  logic [2:0]    rm_addr;
  logic [2:0]    rn_addr;
  logic [2:0]    rb_addr;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;
  logic [DW-1:0] wb_din;
  logic [DW:0]   alu_res;
  logic          cin;

  // Upper opcode bits are decoded by the control FSM, not here.
  logic unused_ins;
  assign unused_ins = ^Ins[15:11];

  assign rd_addr = Ins[10:8];
  assign rm_addr = Ins[7:5];
  assign rn_addr = Ins[4:2];
  assign rb_addr = RBresource ? rd_addr : rn_addr;

  // No write bypass: a register written on this edge still reads its old value.
  assign data_a = rf[rm_addr];
  assign data_b = rf[rb_addr];

  assign Rm   = data_a[7:0];
  assign Rd   = rf[rd_addr][7:0];
  assign OutR = a_exe;

  assign wb_din = WBresource ? (li_exe ? IL_EXE : Sum) : WBData;

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
      a_exe  <= '0;
      b_exe  <= '0;
      IL_EXE <= '0;
      li_exe <= 1'b0;
    end else begin
      if (WBRF) begin
        rf[rd_addr] <= wb_din;
      end
      if (Buff_IDEXE) begin
        a_exe  <= data_a;
        b_exe  <= OprandB ? {{(DW-5){1'b0}}, Ins[4:0]} : data_b;
        li_exe <= LI;
        // RBresource=1 is LHI: imm8 into the high byte, keep the low byte of RF[rd].
        IL_EXE <= RBresource ? {Ins[7:0], data_b[7:0]} : {8'h00, Ins[7:0]};
      end
    end
  end

  // ALU: bit DW of the widened result is carry-out on add and borrow on sub,
  // since both operands are zero-extended before the operation.
  always_comb begin
    cin     = Flag & PSW_C;
    alu_res = '0;
    if (ALUop) begin
      alu_res = {1'b0, a_exe} - {1'b0, b_exe} - {{DW{1'b0}}, cin};
    end else begin
      alu_res = {1'b0, a_exe} + {1'b0, b_exe} + {{DW{1'b0}}, cin};
    end
    Sum = alu_res[DW-1:0];
    C   = alu_res[DW];
    Z   = (alu_res[DW-1:0] == '0);
    N   = alu_res[DW-1];
  end

endmodule

// File: tb/tb_rf_plus_alu.sv
// Purpose: directed self-checking bench for rf_plus_alu.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled before the next edge.
// Backpressure: not applicable.
module tb_rf_plus_alu;

  logic        clk = 1'b0;
  logic        Reset;
  logic [15:0] Ins;
  logic [15:0] WBData;
  logic        WBRF, WBresource, RBresource, OprandB, LI, Buff_IDEXE, ALUop, Flag, PSW_C;
  logic [7:0]  Rm, Rd;
  logic [15:0] IL_EXE, OutR, Sum;
  logic        C, Z, N;

  int n_chk  = 0;
  int n_pass = 0;

  rf_plus_alu #(.DW(16), .NREG(8)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .Ins        (Ins),
    .WBData     (WBData),
    .WBRF       (WBRF),
    .WBresource (WBresource),
    .RBresource (RBresource),
    .OprandB    (OprandB),
    .LI         (LI),
    .Buff_IDEXE (Buff_IDEXE),
    .ALUop      (ALUop),
    .Flag       (Flag),
    .PSW_C      (PSW_C),
    .Rm         (Rm),
    .Rd         (Rd),
    .IL_EXE     (IL_EXE),
    .OutR       (OutR),
    .Sum        (Sum),
    .C          (C),
    .Z          (Z),
    .N          (N)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h want %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write val into RF[r] from the external data path.
  task automatic wr(input logic [2:0] r, input logic [15:0] val);
    Ins = {5'b0, r, 8'h00};
    WBData = val;
    WBresource = 1'b0;
    WBRF = 1'b1;
    tick();
    WBRF = 1'b0;
  endtask

  // Latch RF[rm] / RF[rn] into the EXE buffer.
  task automatic ld(input logic [2:0] rm, input logic [2:0] rn);
    Ins = {8'h00, rm, rn, 2'b00};
    RBresource = 1'b0;
    OprandB = 1'b0;
    LI = 1'b0;
    Buff_IDEXE = 1'b1;
    tick();
    Buff_IDEXE = 1'b0;
  endtask

  // Check the full 16-bit contents of RF[r] through operand A.
  task automatic rdfull(input string tag, input logic [2:0] r, input logic [15:0] exp);
    ld(r, 3'd0);
    chk(tag, {16'h0, OutR}, {16'h0, exp});
  endtask

  initial begin
    Reset = 1'b1; Ins = '0; WBData = '0; WBRF = 0; WBresource = 0; RBresource = 0;
    OprandB = 0; LI = 0; Buff_IDEXE = 0; ALUop = 0; Flag = 0; PSW_C = 0;

    // Reset
    tick(); tick();
    Reset = 1'b0;
    #1;
    chk("rst_outr", OutR, 16'h0);
    chk("rst_il",   IL_EXE, 16'h0);
    chk("rst_rm",   Rm, 8'h0);
    chk("rst_rd",   Rd, 8'h0);
    chk("rst_sum",  Sum, 16'h0);
    chk("rst_c",    C, 1'b0);
    chk("rst_z",    Z, 1'b1);
    chk("rst_n",    N, 1'b0);

    // Fill all registers, then read back through Rd and Rm
    for (int i = 0; i < 8; i++) wr(i[2:0], 16'h1000 + i[15:0]);
    for (int i = 0; i < 8; i++) begin
      Ins = {5'b0, i[2:0], i[2:0], 5'b0};
      #1;
      chk($sformatf("rd_%0d", i), Rd, i[7:0]);
      chk($sformatf("rm_%0d", i), Rm, i[7:0]);
    end
    rdfull("rf5_full", 3'd5, 16'h1005);

    // LLI into r3
    Ins = 16'h03A5; LI = 1; RBresource = 0; OprandB = 0; Buff_IDEXE = 1;
    tick();
    Buff_IDEXE = 0; LI = 0;
    chk("lli_il", IL_EXE, 16'h00A5);
    WBRF = 1; WBresource = 1;
    tick();
    WBRF = 0; WBresource = 0;
    chk("lli_rd", Rd, 8'hA5);
    rdfull("lli_wb", 3'd3, 16'h00A5);

    // LHI into r2
    wr(3'd2, 16'h1234);
    Ins = {5'b0, 3'd2, 8'h5C}; LI = 1; RBresource = 1; Buff_IDEXE = 1;
    tick();
    Buff_IDEXE = 0; LI = 0; RBresource = 0;
    chk("lhi_il", IL_EXE, 16'h5C34);
    WBRF = 1; WBresource = 1;
    tick();
    WBRF = 0; WBresource = 0;
    rdfull("lhi_wb", 3'd2, 16'h5C34);

    // ADD / ADC
    wr(3'd4, 16'hFFFF); wr(3'd5, 16'h0001); ld(3'd4, 3'd5);
    ALUop = 0; Flag = 0; PSW_C = 0; #1;
    chk("add_sum", Sum, 16'h0000); chk("add_c", C, 1'b1);
    chk("add_z", Z, 1'b1);         chk("add_n", N, 1'b0);
    PSW_C = 1; #1;
    chk("add_gated_cin", Sum, 16'h0000);
    Flag = 1; #1;
    chk("adc_sum", Sum, 16'h0001); chk("adc_c", C, 1'b1); chk("adc_z", Z, 1'b0);

    // SUB / SBB
    Flag = 0; PSW_C = 0; ALUop = 1;
    wr(3'd4, 16'h0003); ld(3'd4, 3'd5);   // r5 = 1 here, 3-1
    chk("sub_small", Sum, 16'h0002); chk("sub_small_c", C, 1'b0);
    wr(3'd5, 16'h0005); ld(3'd4, 3'd5);
    chk("sub_sum", Sum, 16'hFFFE); chk("sub_c", C, 1'b1); chk("sub_n", N, 1'b1);
    wr(3'd4, 16'h0005); ld(3'd4, 3'd5);
    chk("sub_eq_sum", Sum, 16'h0000); chk("sub_eq_z", Z, 1'b1); chk("sub_eq_c", C, 1'b0);
    Flag = 1; PSW_C = 1; #1;
    chk("sbb_sum", Sum, 16'hFFFF); chk("sbb_c", C, 1'b1); chk("sbb_n", N, 1'b1);

    // Write the ALU result back into r6
    Ins = {5'b0, 3'd6, 8'h00}; WBRF = 1; WBresource = 1;
    tick();
    WBRF = 0; WBresource = 0; Flag = 0; PSW_C = 0; ALUop = 0;
    rdfull("alu_wb", 3'd6, 16'hFFFF);

    // Immediate operand
    wr(3'd1, 16'h0010);
    Ins = {8'h00, 3'd1, 5'h1F}; OprandB = 1; Buff_IDEXE = 1;
    tick();
    Buff_IDEXE = 0; OprandB = 0;
    chk("imm_sum",  Sum, 16'h002F);
    chk("imm_outr", OutR, 16'h0010);

    // Hold with Ins changed
    Ins = {8'h00, 3'd4, 3'd5, 2'b00};
    tick();
    chk("hold_sum",  Sum, 16'h002F);
    chk("hold_outr", OutR, 16'h0010);

    // Simultaneous write and buffer load of r1: buffer sees old value
    Ins = {5'b0, 3'd1, 3'd1, 5'b0}; WBData = 16'h7777; WBRF = 1; WBresource = 0; Buff_IDEXE = 1;
    #1;
    chk("no_bypass_rm", Rm, 8'h10);
    tick();
    WBRF = 0; Buff_IDEXE = 0;
    chk("wr_ld_old", OutR, 16'h0010);
    rdfull("wr_ld_new", 3'd1, 16'h7777);

    // Reset mid-operation discards the pending write
    Ins = {5'b0, 3'd7, 3'd7, 5'b0}; WBData = 16'hBEEF; WBRF = 1; Buff_IDEXE = 1; LI = 1; Reset = 1;
    tick();
    Reset = 0; WBRF = 0; Buff_IDEXE = 0; LI = 0;
    #1;
    chk("mid_rst_outr", OutR, 16'h0);
    chk("mid_rst_il",   IL_EXE, 16'h0);
    chk("mid_rst_rm",   Rm, 8'h0);
    chk("mid_rst_rd",   Rd, 8'h0);
    chk("mid_rst_sum",  Sum, 16'h0);
    rdfull("mid_rst_r7", 3'd7, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
